// File: rtl/tpu_perf_pkg.sv
// Shared types and constants for the TPU performance monitor.
// Holds the monitor state encoding, the result-select map and the IPC fixed-point format.
package tpu_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perf_state_e;

  localparam int SEL_CYCLE = 0;
  localparam int SEL_INSTR = 1;
  localparam int SEL_STALL = 2;
  localparam int SEL_IPC   = 3;
  localparam int SEL_BUSY0 = 4;

  // Q1.8 result: 256 = 1.0 instructions per cycle, 9 significant bits.
  localparam int IPC_FRAC = 8;
  localparam int IPC_W    = IPC_FRAC + 1;

endpackage

// File: rtl/tpu_perf_div.sv
// Restoring serial divider with a start/busy/valid handshake, one quotient bit per cycle.
// A zero divisor yields quotient 0 one cycle after start; abort_i drops busy and valid at once.
module tpu_perf_div #(
  parameter int DW = 32,
  parameter int QW = 40,
  parameter int OW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort_i,
  input  logic          start_i,
  input  logic [QW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          busy_o,
  output logic          valid_o,
  output logic [OW-1:0] quotient_o
);

  localparam int CW = $clog2(QW + 1);

  logic [QW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [DW:0]   trial;
  logic          ge;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    trial   = {rem_q, quo_q[QW-1]};
    ge      = (trial >= {1'b0, div_q});
    if (abort_i) begin
      busy_d  = 1'b0;
      valid_d = 1'b0;
    end else if (start_i) begin
      quo_d   = dividend_i;
      rem_d   = '0;
      div_d   = divisor_i;
      cnt_d   = CW'(QW);
      busy_d  = 1'b1;
      valid_d = 1'b0;
    end else if (busy_q) begin
      if (div_q == '0) begin
        quo_d   = '0;
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end else begin
        // Remainder stays below the divisor, so the low DW bits carry the exact difference.
        quo_d = {quo_q[QW-2:0], ge};
        rem_d = ge ? (trial[DW-1:0] - div_q) : trial[DW-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign quotient_o = quo_q[OW-1:0];

endmodule

// File: rtl/tpu_perf_monitor.sv
// Windowed performance monitor: cycles, instructions, stalls and per-unit busy counts.
// Optional IPC result (Q1.8) compiled in with PERF_IPC_EN; results read via a registered select port.
module tpu_perf_monitor
  import tpu_perf_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int NUM_UNITS = 4,
  parameter int WIN_W     = 16,
  parameter int SEL_W     = $clog2(NUM_UNITS + 4)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  input  logic [WIN_W-1:0]     window_len,
  input  logic                 instr_valid,
  input  logic                 pipeline_stall,
  input  logic [NUM_UNITS-1:0] unit_busy,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [CNT_W-1:0]     rd_data,
  output logic                 active,
  output logic                 done,
  output logic                 ovf,
  output logic                 ipc_valid
);

  perf_state_e      state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] busy_cnt_q [NUM_UNITS];
  logic [CNT_W-1:0] busy_cnt_d [NUM_UNITS];
  logic [WIN_W-1:0] remaining_q, remaining_d;
  logic             win_en_q, win_en_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] rd_data_q, rd_mux;
  logic [CNT_W-1:0] ipc_ext;
  logic             ipc_valid_w;

  // Priority: clear > start > stop > window expiry.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < NUM_UNITS; i++) busy_cnt_d[i] = busy_cnt_q[i];
    remaining_d = remaining_q;
    win_en_d    = win_en_q;
    ovf_d       = ovf_q;
    if (clear || start) begin
      state_d     = clear ? ST_IDLE : ST_RUN;
      cycle_cnt_d = '0;
      instr_cnt_d = '0;
      stall_cnt_d = '0;
      for (int i = 0; i < NUM_UNITS; i++) busy_cnt_d[i] = '0;
      ovf_d       = 1'b0;
      win_en_d    = clear ? 1'b0 : (|window_len);
      remaining_d = clear ? '0 : window_len;
    end else if (state_q == ST_RUN) begin
      if (stop) begin
        state_d = ST_DONE;
      end else begin
        // Saturating increments: a count already at all-ones holds and flags overflow.
        if (&cycle_cnt_q) ovf_d = 1'b1;
        else cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (instr_valid) begin
          if (&instr_cnt_q) ovf_d = 1'b1;
          else instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
        if (pipeline_stall) begin
          if (&stall_cnt_q) ovf_d = 1'b1;
          else stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        for (int i = 0; i < NUM_UNITS; i++) begin
          if (unit_busy[i]) begin
            if (&busy_cnt_q[i]) ovf_d = 1'b1;
            else busy_cnt_d[i] = busy_cnt_q[i] + CNT_W'(1);
          end
        end
        if (win_en_q) begin
          if (remaining_q == WIN_W'(1)) state_d = ST_DONE;
          else remaining_d = remaining_q - WIN_W'(1);
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (int'(rd_sel))
      SEL_CYCLE: rd_mux = cycle_cnt_q;
      SEL_INSTR: rd_mux = instr_cnt_q;
      SEL_STALL: rd_mux = stall_cnt_q;
      SEL_IPC:   rd_mux = ipc_ext;
      default: begin
        for (int i = 0; i < NUM_UNITS; i++) begin
          if (int'(rd_sel) == SEL_BUSY0 + i) rd_mux = busy_cnt_q[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < NUM_UNITS; i++) busy_cnt_q[i] <= '0;
      remaining_q <= '0;
      win_en_q    <= 1'b0;
      ovf_q       <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < NUM_UNITS; i++) busy_cnt_q[i] <= busy_cnt_d[i];
      remaining_q <= remaining_d;
      win_en_q    <= win_en_d;
      ovf_q       <= ovf_d;
      rd_data_q   <= rd_mux;
    end
  end

`ifdef PERF_IPC_EN
  logic             div_start;
  logic             div_busy;
  logic [IPC_W-1:0] ipc_q;

  // Operands come from the next-state counters so the final counted cycle is included.
  assign div_start = (state_q == ST_RUN) && (state_d == ST_DONE) && !div_busy;

  tpu_perf_div #(
    .DW(CNT_W),
    .QW(CNT_W + IPC_FRAC),
    .OW(IPC_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .abort_i    (start | clear),
    .start_i    (div_start),
    .dividend_i ({instr_cnt_d, {IPC_FRAC{1'b0}}}),
    .divisor_i  (cycle_cnt_d),
    .busy_o     (div_busy),
    .valid_o    (ipc_valid_w),
    .quotient_o (ipc_q)
  );

  if (CNT_W >= IPC_W) begin : g_ipc_ext
    assign ipc_ext = CNT_W'(ipc_q);
  end else begin : g_ipc_trunc
    assign ipc_ext = ipc_q[CNT_W-1:0];
  end
`else
  assign ipc_valid_w = 1'b0;
  assign ipc_ext     = '0;
`endif

  assign rd_data   = rd_data_q;
  assign active    = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign ovf       = ovf_q;
  assign ipc_valid = ipc_valid_w;

endmodule

// File: tb/tb_tpu_perf_monitor.sv
// Directed bench for tpu_perf_monitor: a default-width instance plus a CNT_W=4 instance
// sharing the same stimulus for the saturation case. IPC checks follow PERF_IPC_EN.
module tb_tpu_perf_monitor;
  import tpu_perf_pkg::*;

  localparam int CNT_W     = 32;
  localparam int NUM_UNITS = 4;
  localparam int WIN_W     = 16;
  localparam int SEL_W     = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 stop = 1'b0;
  logic                 clear = 1'b0;
  logic [WIN_W-1:0]     window_len = '0;
  logic                 instr_valid = 1'b0;
  logic                 pipeline_stall = 1'b0;
  logic [NUM_UNITS-1:0] unit_busy = '0;
  logic [SEL_W-1:0]     rd_sel = '0;
  logic [CNT_W-1:0]     rd_data;
  logic                 active, done, ovf, ipc_valid;
  logic [3:0]           rd_data_s;
  logic                 active_s, done_s, ovf_s, ipc_valid_s;

  int checks = 0;
  int errors = 0;

  tpu_perf_monitor #(
    .CNT_W(CNT_W), .NUM_UNITS(NUM_UNITS), .WIN_W(WIN_W), .SEL_W(SEL_W)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .window_len(window_len), .instr_valid(instr_valid),
    .pipeline_stall(pipeline_stall), .unit_busy(unit_busy), .rd_sel(rd_sel),
    .rd_data(rd_data), .active(active), .done(done), .ovf(ovf),
    .ipc_valid(ipc_valid)
  );

  tpu_perf_monitor #(
    .CNT_W(4), .NUM_UNITS(NUM_UNITS), .WIN_W(WIN_W), .SEL_W(SEL_W)
  ) u_small (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .window_len(window_len), .instr_valid(instr_valid),
    .pipeline_stall(pipeline_stall), .unit_busy(unit_busy), .rd_sel(rd_sel),
    .rd_data(rd_data_s), .active(active_s), .done(done_s), .ovf(ovf_s),
    .ipc_valid(ipc_valid_s)
  );

  // Clock: rising edges at 5, 15, ...; the bench drives and samples on falling edges.
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic read_sel(input int sel, output logic [31:0] v, output logic [31:0] vs);
    rd_sel = SEL_W'(sel);
    tick();
    v  = rd_data;
    vs = 32'(rd_data_s);
  endtask

  task automatic wait_ipc(input int budget);
    int n = 0;
    while (!ipc_valid && n < budget) begin
      tick();
      n++;
    end
    check("ipc_valid_within_budget", 32'(ipc_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] v, vs;

    // Reset
    repeat (3) tick();
    rst = 1'b0;
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ipc_valid", 32'(ipc_valid), 32'd0);

    // Fixed window of 20, instruction every cycle
    start = 1'b1; window_len = 16'd20; instr_valid = 1'b1;
    tick();
    start = 1'b0;
    check("w20_active", 32'(active), 32'd1);
    check("w20_ovf_start", 32'(ovf), 32'd0);
    repeat (19) tick();
    check("w20_not_early", 32'(done), 32'd0);
    tick();
    check("w20_done", 32'(done), 32'd1);
    check("w20_inactive", 32'(active), 32'd0);
    check("small_done", 32'(done_s), 32'd1);
    check("small_ovf", 32'(ovf_s), 32'd1);
    check("w20_no_ovf", 32'(ovf), 32'd0);
`ifdef PERF_IPC_EN
    repeat (39) tick();
    check("w20_ipc_not_yet", 32'(ipc_valid), 32'd0);
    tick();
    check("w20_ipc_valid", 32'(ipc_valid), 32'd1);
`else
    check("w20_ipc_absent", 32'(ipc_valid), 32'd0);
`endif
    read_sel(SEL_CYCLE, v, vs);
    check("w20_cycle", v, 32'd20);
    check("small_cycle_sat", vs, 32'd15);
    read_sel(SEL_INSTR, v, vs);
    check("w20_instr", v, 32'd20);
    check("small_instr_sat", vs, 32'd15);
    read_sel(SEL_STALL, v, vs);
    check("w20_stall", v, 32'd0);
    read_sel(SEL_IPC, v, vs);
`ifdef PERF_IPC_EN
    check("w20_ipc_q8", v, 32'd256);
`else
    check("w20_ipc_q8_absent", v, 32'd0);
`endif

    // Clear returns to IDLE with counters and ovf zeroed
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_small_ovf", 32'(ovf_s), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    check("clr_ipc_valid", 32'(ipc_valid), 32'd0);
    read_sel(SEL_CYCLE, v, vs);
    check("clr_cycle", v, 32'd0);
    check("clr_small_cycle", vs, 32'd0);

    // Unbounded window, alternating instructions, 5 stalls, stop after 40
    start = 1'b1; window_len = 16'd0; instr_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      instr_valid    = (i % 2 == 0);
      pipeline_stall = (i < 5);
      tick();
    end
    stop = 1'b1; instr_valid = 1'b1; pipeline_stall = 1'b1;
    tick();
    stop = 1'b0; instr_valid = 1'b0; pipeline_stall = 1'b0;
    check("stop_done", 32'(done), 32'd1);
    check("stop_inactive", 32'(active), 32'd0);
    read_sel(SEL_CYCLE, v, vs);
    check("stop_cycle", v, 32'd40);
    read_sel(SEL_INSTR, v, vs);
    check("stop_instr", v, 32'd20);
    read_sel(SEL_STALL, v, vs);
    check("stop_stall", v, 32'd5);
`ifdef PERF_IPC_EN
    wait_ipc(60);
    read_sel(SEL_IPC, v, vs);
    check("stop_ipc_q8", v, 32'd128);
`endif

    // Per-unit busy pattern 0101 for 10 counted cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    rd_sel = SEL_W'(SEL_CYCLE);
    unit_busy = 4'b0101;
    repeat (10) tick();
    check("busy_live_cycle", rd_data, 32'd9);
    unit_busy = 4'b1111; stop = 1'b1;
    tick();
    unit_busy = 4'b0000; stop = 1'b0;
    check("busy_done", 32'(done), 32'd1);
    read_sel(SEL_BUSY0 + 0, v, vs);
    check("busy0", v, 32'd10);
    read_sel(SEL_BUSY0 + 1, v, vs);
    check("busy1", v, 32'd0);
    read_sel(SEL_BUSY0 + 2, v, vs);
    check("busy2", v, 32'd10);
    read_sel(SEL_BUSY0 + 3, v, vs);
    check("busy3", v, 32'd0);

    // start + stop together while running: restart wins
    start = 1'b1; instr_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    rd_sel = SEL_W'(SEL_CYCLE);
    check("restart_active", 32'(active), 32'd1);
    check("restart_not_done", 32'(done), 32'd0);
    tick();
    check("restart_zeroed", rd_data, 32'd0);
    tick();
    check("restart_counting", rd_data, 32'd1);

    // clear + start together: clear wins
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    check("clr_start_inactive", 32'(active), 32'd0);
    check("clr_start_not_done", 32'(done), 32'd0);
    tick();
    check("clr_start_cycle", rd_data, 32'd0);

    // rst in cycle 7 of a 20-cycle window
    start = 1'b1; window_len = 16'd20;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("pre_rst_live", rd_data, 32'd6);
    rst = 1'b1;
    tick();
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_rd_data", rd_data, 32'd0);
    check("mid_rst_ipc_valid", 32'(ipc_valid), 32'd0);
    rst = 1'b0; instr_valid = 1'b0;
    tick();
    check("post_rst_idle", 32'(active), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_perf_monitor.md
# tpu_perf_monitor

Parametrised hardware performance monitor that sits beside `tpu_controller` and measures instruction throughput in silicon rather than in a bench. It counts measurement-window cycles, issued instructions, stall cycles and per-unit busy cycles over a software-controlled or fixed-length window. With the IPC option compiled in, it also produces a fixed-point instructions-per-cycle result. All results are read through a registered select/data port.

## Interface
Parameters:
- CNT_W, 32: width of every event counter
- NUM_UNITS, 4: number of busy inputs monitored (sys, vpu, dma, wt order at default)
- WIN_W, 16: width of window_len
- SEL_W, $clog2(NUM_UNITS+4): width of rd_sel

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; (re)start measurement
- stop  in  1  pulse; end measurement
- clear  in  1  pulse; zero all counters and return to IDLE
- window_len  in  WIN_W  cycles per window, sampled on start; 0 = unbounded
- instr_valid  in  1  one instruction issued this cycle (controller pc_cnt)
- pipeline_stall  in  1  controller stall this cycle
- unit_busy  in  NUM_UNITS  per-unit busy flags
- rd_sel  in  SEL_W  result select
- rd_data  out  CNT_W  selected result, registered
- active  out  1  state == RUN
- done  out  1  state == DONE
- ovf  out  1  sticky: any counter saturated
- ipc_valid  out  1  IPC result ready (0 when feature absent)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start → RUN (counters zeroed, window_len latched, remaining = window_len).
- RUN: each cycle, cycle_cnt++, instr_cnt += instr_valid, stall_cnt += pipeline_stall, busy_cnt[i] += unit_busy[i]. stop → DONE. If latched window ≠ 0 and remaining reaches 1 on this counted cycle → DONE after that cycle.
- DONE: counters frozen; start → RUN (restart); clear → IDLE.
- Priority in one cycle: clear > start > stop > window expiry. start in RUN restarts the measurement, zeroing counters.
- Counters saturate at all-ones and never wrap. Any saturation sets ovf, which is cleared only by clear, start, or rst.
- rd_sel: 0 cycle_cnt, 1 instr_cnt, 2 stall_cnt, 3 ipc_q8 (zero-extended; 0 if absent), 4+i busy_cnt[i]. Out-of-range selects return 0.
- Reset values: rd_data 0, active 0, done 0, ovf 0, ipc_valid 0, all counters 0.

## Timing
- start asserted in cycle T: active = 1 from T+1. Inputs at T+1 are the first counted cycle.
- stop asserted in cycle T while RUN: that cycle's inputs are not counted. done = 1 from T+1.
- window_len = N: exactly N cycles are counted. done rises the cycle after the Nth counted cycle.
- rd_data reflects the rd_sel of the previous cycle (1-cycle latency). It tracks live counter values during RUN.
- rst mid-RUN or mid-divide: everything returns to reset values on the next edge; any in-flight IPC result is discarded.

## Configuration
- PERF_IPC_EN defined: on entry to DONE, a sequential divider computes ipc_q8 = floor((instr_cnt << 8) / cycle_cnt). The result is 9 significant bits, Q1.8, with 256 = 1.0 IPC.
  - The divider takes CNT_W+8 cycles. ipc_valid then rises and stays high until start, clear, or rst.
  - If cycle_cnt = 0, the result is 0 and ipc_valid rises on the cycle after DONE entry.
  - start or clear during the divide aborts it.
- PERF_IPC_EN undefined: no divider is instantiated, ipc_valid is tied 0, and rd_sel 3 returns 0.

## Structure
- Shared package tpu_perf_pkg holds:
  - state enum (IDLE/RUN/DONE)
  - rd_sel encodings (SEL_CYCLE, SEL_INSTR, SEL_STALL, SEL_IPC, SEL_BUSY0)
  - IPC_FRAC = 8
- One sub-module, tpu_perf_div: a restoring serial divider with start/busy/valid handshake. It is instantiated only under PERF_IPC_EN.

## Test plan
- window_len = 20, instr_valid held 1, no stalls → done after 20 cycles. Reads: cycle 20, instr 20, stall 0; ipc_q8 = 256 with PERF_IPC_EN.
- window_len = 0, instr_valid alternating 1/0, stall high 5 cycles, stop after 40 cycles → cycle 40, instr 20, stall 5, ipc_q8 = 128.
- unit_busy = 4'b0101 for 10 counted cycles, then stop → busy_cnt[0] = busy_cnt[2] = 10, busy_cnt[1] = busy_cnt[3] = 0.
- CNT_W = 4, window_len = 20, instr_valid 1 → cycle_cnt and instr_cnt read 15, ovf = 1. After clear: ovf = 0 and counters 0.
- start and stop in the same cycle while RUN → restart wins: counters zeroed, active stays 1. clear + start together → IDLE.
- rst asserted mid-window (cycle 7 of 20) → next cycle active 0, done 0, rd_data 0, ipc_valid 0.
